// File: rtl/meansq_acc_pkg.sv
// Shared fixed-point constants and the mean-square accumulator state encoding.
package meansq_acc_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int FBITS_DEF = 8;
    localparam int LOG2N_DEF = 3;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } ms_state_e;
endpackage

// File: rtl/meansq_acc.sv
// Accumulates squares of N samples and hands mean square (Q format) to a sqrt stage.
// Latency: radicand registered 3 cycles after the Nth accepted sample.
// Backpressure: in_ready low from Nth acceptance until the cycle after sq_valid; START holds while sq_busy.
module meansq_acc
    import meansq_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FBITS = FBITS_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sq_start,
    output logic [WIDTH-1:0] sq_rad,
    input  logic             sq_busy,
    input  logic             sq_valid
);
    localparam int N  = 1 << LOG2N;
    localparam int AW = 2 * WIDTH + LOG2N;

    ms_state_e state, nxt;

    logic [LOG2N:0]          cnt;
    logic [LOG2N:0]          acc_cnt;
    logic [2*WIDTH-1:0]      prod;
    logic                    prod_vld;
    logic [AW-1:0]           acc;
    logic [WIDTH-1:0]        rad_q;
    logic                    accept;
    logic                    acc_done;
    logic                    clear;
    logic signed [2*WIDTH-1:0] sq_full;
    logic [AW-1:0]           shifted;
    logic [WIDTH-1:0]        rad_sat;

    assign accept   = in_valid && in_ready;
    assign sq_full  = $signed(in_data) * $signed(in_data);
    assign acc_done = (acc_cnt == (LOG2N+1)'(N));

    // mean = acc >> LOG2N, then drop the fractional bits: one combined truncating shift
    assign shifted  = acc >> (LOG2N + FBITS);
    assign rad_sat  = (|shifted[AW-1:WIDTH]) ? '1 : shifted[WIDTH-1:0];
    assign sq_rad   = rad_q;

    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        sq_start = 1'b0;
        clear    = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (accept && cnt == (LOG2N+1)'(N - 1))
                    nxt = DRAIN;
            end
            DRAIN: begin
                if (acc_done)
                    nxt = START;
            end
            START: begin
                if (!sq_busy) begin
                    sq_start = rst_n;
                    nxt      = WAIT;
                end
            end
            WAIT: begin
                if (sq_valid) begin
                    clear = 1'b1;
                    nxt   = ACC;
                end
            end
            default: nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ACC;
            cnt      <= '0;
            acc_cnt  <= '0;
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            rad_q    <= '0;
        end else begin
            state    <= nxt;
            prod_vld <= accept;
            if (accept) begin
                cnt  <= cnt + 1'b1;
                prod <= sq_full;
            end
            if (prod_vld) begin
                acc     <= acc + AW'(prod);
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (state == DRAIN && acc_done)
                rad_q <= rad_sat;
            if (clear) begin
                cnt      <= '0;
                acc_cnt  <= '0;
                acc      <= '0;
                prod_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_meansq_acc.sv
// Self-checking bench for meansq_acc: directed and randomized frames against an arithmetic model.
module tb_meansq_acc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        sq_start;
    logic [15:0] sq_rad;
    logic        sq_busy = 1'b0;
    logic        sq_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    meansq_acc #(.WIDTH(16), .FBITS(8), .LOG2N(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sq_start (sq_start),
        .sq_rad   (sq_rad),
        .sq_busy  (sq_busy),
        .sq_valid (sq_valid)
    );

    // Mean square of eight signed Q8.8 samples, expressed as a Q8.8 unsigned value.
    function automatic logic [15:0] model(input logic [15:0] s [8]);
        longint sum = 0;
        longint mean, rad;
        for (int i = 0; i < 8; i++) begin
            longint v = longint'($signed(s[i]));
            sum += v * v;
        end
        mean = sum / 8;
        rad  = mean / 256;
        if (rad > 65535) rad = 65535;
        return rad[15:0];
    endfunction

    // Drives one frame and plays the sqrt stage; reports starts seen, captured radicand, protocol errors.
    task automatic run_frame(input logic [15:0] s [8], input bit toggle, input int busy_len,
                             input int vdelay, input bit spurious,
                             output int starts, output logic [15:0] rad, output int bad);
        int  acc_n = 0;
        int  after = -1;
        int  wait_cnt = -1;
        int  t = 0;
        bit  ret = 0;
        bit  done = 0;
        bit  sp_done = 0;
        bit  vld_now;
        starts = 0; rad = '0; bad = 0;
        while (!done && t < 500) begin
            @(posedge clk); #1; t++;
            vld_now = 0;
            if (ret) begin
                in_valid = 1'b0;
                sq_valid = 1'b0;
            end else begin
                if (acc_n < 8)
                    in_valid = !toggle || t[0];
                else
                    in_valid = 1'($urandom_range(0, 1));
                in_data  = (acc_n < 8 && in_valid) ? s[acc_n] : 16'($urandom);
                sq_busy  = (after >= 0 && after < busy_len);
                vld_now  = (wait_cnt >= 0 && wait_cnt == vdelay - 1);
                sq_valid = vld_now;
                if (spurious && !sp_done && acc_n == 3) begin
                    sq_valid = 1'b1;
                    sp_done  = 1;
                end
            end
            @(negedge clk);
            if (ret) begin
                if (!in_ready) bad++;
                done = 1;
            end else begin
                if (acc_n == 8 && in_ready) bad++;
                if (sq_start) begin
                    starts++;
                    if (sq_busy || acc_n < 8) bad++;
                    rad = sq_rad;
                    wait_cnt = 0;
                end else if (wait_cnt >= 0) begin
                    wait_cnt++;
                end
                if (starts > 0 && sq_rad !== rad) bad++;
                if (vld_now) ret = 1;
                if (in_valid && in_ready) begin
                    acc_n++;
                    if (acc_n == 8) after = 0;
                end else if (after >= 0) begin
                    after++;
                end
            end
        end
        if (!done) bad++;
        in_valid = 1'b0; sq_valid = 1'b0; sq_busy = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [15:0] s [8], input bit toggle,
                               input int busy_len, input int vdelay, input bit spurious);
        int starts, bad;
        logic [15:0] rad, exp_rad;
        exp_rad = model(s);
        run_frame(s, toggle, busy_len, vdelay, spurious, starts, rad, bad);
        checks++;
        if (starts !== 1) begin
            failures++;
            $display("FAIL %s starts: got %0d want 1", name, starts);
        end
        checks++;
        if (rad !== exp_rad) begin
            failures++;
            $display("FAIL %s sq_rad: got %h want %h", name, rad, exp_rad);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s protocol: got %0d errors want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sq_start !== 1'b0) begin failures++; $display("FAIL reset_sq_start: got %b want 0", sq_start); end
        checks++;
        if (sq_rad !== 16'h0000) begin failures++; $display("FAIL reset_sq_rad: got %h want 0000", sq_rad); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [15:0] s [8];
        for (int i = 0; i < 8; i++) s[i] = 16'h0200;
        check_frame("two", s, 0, 0, 3, 0);
        for (int i = 0; i < 8; i++) s[i] = 16'hFE80;
        check_frame("neg1p5", s, 0, 0, 3, 0);
        for (int i = 0; i < 8; i++) s[i] = (i < 4) ? 16'h0100 : 16'h0000;
        check_frame("half", s, 0, 0, 2, 0);
        for (int i = 0; i < 8; i++) s[i] = 16'h7FFF;
        check_frame("saturate", s, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) s[i] = 16'h0001;
        check_frame("truncate", s, 0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        logic [15:0] s [8];
        for (int i = 0; i < 8; i++) s[i] = 16'($urandom);
        check_frame("backpressure", s, 1, 5, 16, 0);
    endtask

    task automatic test_reset_midframe();
        logic [15:0] s [8];
        int starts = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 16'h7FFF;
            @(negedge clk);
            if (sq_start) starts++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        if (sq_start) starts++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (starts !== 0) begin failures++; $display("FAIL midreset_no_start: got %0d want 0", starts); end
        for (int i = 0; i < 8; i++) s[i] = 16'h0200;
        check_frame("after_reset", s, 0, 0, 3, 0);
    endtask

    task automatic test_spurious_valid();
        logic [15:0] s [8];
        for (int i = 0; i < 8; i++) s[i] = 16'h0200;
        check_frame("spurious", s, 0, 0, 3, 1);
    endtask

    task automatic test_random();
        logic [15:0] s [8];
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++)
                s[i] = (f < 3) ? 16'($urandom) : 16'($urandom_range(0, 16'h0600) - 16'h0300);
            check_frame("random", s, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                        $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midframe();
        test_spurious_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/meansq_acc.md
MEANSQ_ACC -- requirements
Module: meansq_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample and radicand width in bits.
REQ-002 SHALL have parameter FBITS, default 8, fractional bits (Q8.8 at defaults).
REQ-003 SHALL have parameter LOG2N, default 3, log2 of samples per frame (N=8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  sample offered.
REQ-007 SHALL have port in_data  input  WIDTH  signed two's-complement fixed-point sample.
REQ-008 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port sq_start  output  1  one-cycle start pulse to the downstream sqrt.
REQ-010 SHALL have port sq_rad  output  WIDTH  unsigned radicand (mean square) to the sqrt.
REQ-011 SHALL have port sq_busy  input  1  sqrt calculation in progress.
REQ-012 SHALL have port sq_valid  input  1  sqrt root/rem valid; ends the frame.

Function
REQ-013 SHALL accept a sample on a cycle with in_valid && in_ready; no other cycle counts.
REQ-014 SHALL implement states ACC, DRAIN, START, WAIT.
REQ-015 ACC: in_ready=1; sample counter increments per accepted sample; on the Nth acceptance the next state is DRAIN.
REQ-016 SHALL square each accepted sample into a 2*WIDTH-bit unsigned product register one cycle after acceptance (pipeline stage with its own valid flag).
REQ-017 SHALL add each registered product into a (2*WIDTH+LOG2N)-bit accumulator in the cycle after the product is registered; no overflow possible.
REQ-018 DRAIN: in_ready=0; stays until the Nth product has been accumulated, then goes to START.
REQ-019 SHALL compute mean = acc >> LOG2N, then radicand = mean >> FBITS (truncation, no rounding).
REQ-020 SHALL saturate the radicand to all-ones (16'hFFFF at defaults) when it exceeds WIDTH unsigned bits.
REQ-021 SHALL register sq_rad on entry to START and hold it stable until sq_valid is seen in WAIT.
REQ-022 START: in_ready=0; if sq_busy=0, asserts sq_start for exactly one cycle and goes to WAIT; if sq_busy=1, holds in START with sq_start=0.
REQ-023 WAIT: in_ready=0, sq_start=0; on sq_valid=1 clears accumulator, counter and product valid and returns to ACC (in_ready=1 the following cycle).
REQ-024 SHALL ignore sq_valid in any state other than WAIT.
REQ-025 SHALL ignore in_data whenever in_ready=0, regardless of in_valid.

Reset
REQ-026 On rst_n=0 at a clock edge SHALL enter ACC and clear counter, accumulator, product register/valid and sq_rad to 0.
REQ-027 During and after reset SHALL drive sq_start=0 and in_ready=1 (first cycle after release).
REQ-028 Reset mid-frame or in WAIT SHALL discard the partial frame; no sq_start is issued for it.

Structure
REQ-029 SHALL place state encoding (ACC/DRAIN/START/WAIT) and default WIDTH/FBITS/LOG2N constants in the shared fixed-point package used by the sqrt stage.
REQ-030 SHALL be a single module with no sub-modules; the squarer is inline.

Verification
REQ-031 8 x 0x0200 (2.0), sqrt valid 3 cycles after start -> one sq_start pulse, sq_rad=0x0400 (4.0).
REQ-032 8 x 0xFE80 (-1.5) -> sq_rad=0x0240 (2.25); 4 x 0x0100 then 4 x 0x0000 -> sq_rad=0x0080 (0.5).
REQ-033 8 x 0x7FFF -> sq_rad=0xFFFF (saturated); 8 x 0x0001 -> sq_rad=0x0000 (truncated).
REQ-034 in_valid toggled every other cycle, sq_busy held 1 for 5 cycles after DRAIN, sq_valid delayed 16 cycles -> sq_start only after sq_busy falls, in_ready=0 from Nth acceptance until cycle after sq_valid, sq_rad stable throughout.
REQ-035 rst_n low for 1 cycle after 5 accepted samples, then 8 x 0x0200 -> exactly one sq_start, sq_rad=0x0400.
REQ-036 Spurious sq_valid pulse during ACC -> no state change, frame result unaffected.
